// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared LeNet-5 accelerator constants and scheduler state encodings
package lenet_pkg;

  localparam int N_LAYERS = 7;
  localparam int GRAPH_W  = 5;

  localparam logic [2:0] L_CONV1 = 3'd0;
  localparam logic [2:0] L_POOL1 = 3'd1;
  localparam logic [2:0] L_CONV2 = 3'd2;
  localparam logic [2:0] L_POOL2 = 3'd3;
  localparam logic [2:0] L_FC1   = 3'd4;
  localparam logic [2:0] L_FC2   = 3'd5;
  localparam logic [2:0] L_FC3   = 3'd6;

  // One-hot, matching the encoding style of the layer FSMs.
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_RUN  = 5'b00010,
    S_GAP  = 5'b00100,
    S_DONE = 5'b01000,
    S_ERR  = 5'b10000
  } sched_state_t;

endpackage

// File: rtl/layer_watchdog.sv
// rtl/layer_watchdog.sv - per-layer enable-time counter with expiry compare
module layer_watchdog #(
  parameter int               CNT_W   = 32,
  parameter logic [CNT_W-1:0] TIMEOUT = 32'd4_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // The count freezes once expired so it cannot wrap past the limit.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == TIMEOUT - CNT_W'(1));

endmodule

// File: rtl/lenet_layer_sched.sv
// rtl/lenet_layer_sched.sv - runs the conv/pool/fc layer chain once per image with a watchdog
module lenet_layer_sched #(
  parameter int               N_LAYERS = lenet_pkg::N_LAYERS,
  parameter int               GRAPH_W  = lenet_pkg::GRAPH_W,
  parameter int               CNT_W    = 32,
  parameter logic [CNT_W-1:0] TIMEOUT  = 32'd4_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [GRAPH_W-1:0]  num_graphs,
  input  logic [N_LAYERS-1:0] layer_finish,
  output logic [N_LAYERS-1:0] layer_en,
  output logic [GRAPH_W-1:0]  graph,
  output logic [2:0]          layer_idx,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [CNT_W-1:0]    cycle_count
);

  import lenet_pkg::*;

  localparam logic [2:0]          LAST_IDX = 3'(N_LAYERS - 1);
  localparam logic [N_LAYERS-1:0] FIRST_EN = N_LAYERS'(1);

  sched_state_t       state;
  logic [GRAPH_W-1:0] num_lat;
  logic [GRAPH_W:0]   graph_next;
  logic               more_graphs;
  logic               finish_hit;
  logic               wd_clr;
  logic               wd_en;
  logic               wd_expired;

  assign graph_next  = {1'b0, graph} + (GRAPH_W + 1)'(1);
  assign more_graphs = graph_next < {1'b0, num_lat};
  assign finish_hit  = layer_finish[layer_idx];
  assign wd_clr      = (state != S_RUN);
  assign wd_en       = (state == S_RUN);

  layer_watchdog #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      num_lat     <= '0;
      layer_en    <= '0;
      graph       <= '0;
      layer_idx   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (busy && cycle_count != '1) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end

      unique case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            error       <= 1'b0;
            cycle_count <= '0;
            if (num_graphs != '0) begin
              num_lat   <= num_graphs;
              graph     <= '0;
              layer_idx <= L_CONV1;
              layer_en  <= FIRST_EN;
              busy      <= 1'b1;
              state     <= S_RUN;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        // Finish is tested first so it wins over a same-cycle expiry.
        S_RUN: begin
          if (finish_hit) begin
            layer_en <= '0;
            state    <= S_GAP;
          end else if (wd_expired) begin
            layer_en <= '0;
            busy     <= 1'b0;
            error    <= 1'b1;
            state    <= S_ERR;
          end
        end

        // One all-zero cycle lets the finished layer settle back to idle.
        S_GAP: begin
          if (layer_idx < LAST_IDX) begin
            layer_idx <= layer_idx + 3'd1;
            layer_en  <= FIRST_EN << (layer_idx + 3'd1);
            state     <= S_RUN;
          end else if (more_graphs) begin
            layer_idx <= L_CONV1;
            graph     <= graph_next[GRAPH_W-1:0];
            layer_en  <= FIRST_EN;
            state     <= S_RUN;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lenet_layer_sched.sv
// tb/tb_lenet_layer_sched.sv - directed bench with a timeline model of the layer scheduler
module tb_lenet_layer_sched;

  localparam int NL = 7;
  localparam int GW = 5;
  localparam int CW = 32;
  localparam int TO = 50;
  localparam int P  = 11;  // 10 enabled cycles (responder delay) plus one gap cycle

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [GW-1:0] num_graphs = '0;
  logic [NL-1:0] layer_finish;
  logic [NL-1:0] resp = '0;
  logic [NL-1:0] stray = '0;
  logic [NL-1:0] layer_en;
  logic [GW-1:0] graph;
  logic [2:0]    layer_idx;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] cycle_count;

  int checks = 0;
  int failures = 0;
  int hang_layer = -1;
  int pulses = 0;
  int en3_cycles = 0;

  bit            m_run = 1'b0;
  int            m_t = 0;
  int            m_g = 0;
  int            m_hang = -1;
  int            seg;
  int            off;
  logic [NL-1:0] e_en = '0;
  logic [GW-1:0] e_graph = '0;
  logic [2:0]    e_idx = '0;
  logic          e_busy = 1'b0;
  logic          e_done = 1'b0;
  logic          e_err = 1'b0;
  logic [CW-1:0] e_cc = '0;
  logic [NL-1:0] prev_en = '0;

  assign layer_finish = resp | stray;

  always #5 clk = ~clk;

  lenet_layer_sched #(
    .N_LAYERS (NL),
    .GRAPH_W  (GW),
    .CNT_W    (CW),
    .TIMEOUT  (CW'(TO))
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_graphs   (num_graphs),
    .layer_finish (layer_finish),
    .layer_en     (layer_en),
    .graph        (graph),
    .layer_idx    (layer_idx),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cycle_count  (cycle_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Layer model: finish the active layer 10 cycles after its enable rises, unless it is the hung one.
  initial begin
    int cnt;
    logic [NL-1:0] last_en;
    logic [NL-1:0] hmask;
    cnt = 0;
    last_en = '0;
    forever begin
      @(negedge clk);
      resp = '0;
      if (layer_en != '0 && layer_en == last_en) cnt++;
      else if (layer_en != '0) cnt = 1;
      else cnt = 0;
      last_en = layer_en;
      hmask = (hang_layer >= 0) ? (NL'(1) << hang_layer) : '0;
      if (cnt == 10 && (layer_en & hmask) == '0) resp = layer_en;
    end
  end

  // Timeline model: with fixed responder delay every layer occupies P cycles after the start edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_run = 1'b0; e_en = '0; e_graph = '0; e_idx = '0;
        e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_cc = '0;
      end else if (!m_run) begin
        if (start && !e_done) begin
          e_err = 1'b0; e_cc = '0; e_done = 1'b0;
          if (num_graphs != '0) begin
            m_run = 1'b1; m_t = 0; m_g = int'(num_graphs); m_hang = hang_layer;
          end else begin
            e_done = 1'b1;
          end
        end else begin
          e_done = 1'b0;
        end
      end else begin
        m_t++;
      end

      if (rst && m_run) begin
        seg = m_t / P;
        off = m_t % P;
        e_cc = CW'(m_t);
        if (m_hang >= 0 && m_t == P * m_hang + TO) begin
          e_en = '0; e_busy = 1'b0; e_err = 1'b1;
          e_idx = 3'(m_hang); e_graph = '0; m_run = 1'b0;
        end else if (m_hang >= 0 && seg >= m_hang) begin
          e_en = NL'(1) << m_hang; e_idx = 3'(m_hang); e_graph = '0; e_busy = 1'b1;
        end else if (seg < NL * m_g) begin
          e_graph = GW'(seg / NL);
          e_idx   = 3'(seg % NL);
          e_en    = (off < P - 1) ? (NL'(1) << (seg % NL)) : '0;
          e_busy  = 1'b1;
        end else begin
          e_en = '0; e_busy = 1'b0; e_done = 1'b1;
          e_graph = GW'(m_g - 1); e_idx = 3'(NL - 1); m_run = 1'b0;
        end
      end

      @(negedge clk);
      check("layer_en",    64'(layer_en),    64'(e_en));
      check("graph",       64'(graph),       64'(e_graph));
      check("layer_idx",   64'(layer_idx),   64'(e_idx));
      check("busy",        64'(busy),        64'(e_busy));
      check("done",        64'(done),        64'(e_done));
      check("error",       64'(error),       64'(e_err));
      check("cycle_count", 64'(cycle_count), 64'(e_cc));
      if (layer_en != '0 && prev_en == '0) pulses++;
      if (layer_en[3]) en3_cycles++;
      prev_en = layer_en;
    end
  end

  task automatic start_batch(input int n);
    pulses = 0;
    en3_cycles = 0;
    start = 1'b1;
    num_graphs = GW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done || error) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_end_reached"}, 64'(ok), 64'(1));
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({layer_en, graph, layer_idx, busy, done, error}), 64'(0));
    check("reset_cycle_count", 64'(cycle_count), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // Single image
    start_batch(1);
    check("t1_first_en", 64'(layer_en), 64'(7'b0000001));
    wait_end(200, "t1");
    check("t1_pulses", 64'(pulses), 64'(7));
    check("t1_cycles", 64'(cycle_count), 64'(77));
    check("t1_done", 64'(done), 64'(1));
    @(negedge clk);

    // Three images, with a start pulse while busy
    start_batch(3);
    repeat (25) @(negedge clk);
    start = 1'b1;
    num_graphs = GW'(5);
    @(negedge clk);
    start = 1'b0;
    check("t2_busy_start_graph", 64'(graph), 64'(0));
    check("t2_busy_start_idx", 64'(layer_idx), 64'(2));
    wait_end(400, "t2");
    check("t2_pulses", 64'(pulses), 64'(21));
    check("t2_cycles", 64'(cycle_count), 64'(231));
    check("t2_graph", 64'(graph), 64'(2));
    @(negedge clk);

    // Stray finish from layer 4 while layer 2 runs
    start_batch(1);
    repeat (24) @(negedge clk);
    stray = 7'b0010000;
    @(negedge clk);
    stray = '0;
    check("t3_stray_en", 64'(layer_en), 64'(7'b0000100));
    check("t3_stray_idx", 64'(layer_idx), 64'(2));
    wait_end(200, "t3");
    check("t3_pulses", 64'(pulses), 64'(7));
    @(negedge clk);

    // Watchdog timeout on layer 3
    hang_layer = 3;
    start_batch(1);
    wait_end(300, "t4");
    check("t4_error", 64'(error), 64'(1));
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_en3_cycles", 64'(en3_cycles), 64'(50));
    check("t4_cycles", 64'(cycle_count), 64'(83));
    check("t4_idx", 64'(layer_idx), 64'(3));
    repeat (3) @(negedge clk);
    hang_layer = -1;
    start_batch(1);
    check("t4_restart_error", 64'(error), 64'(0));
    check("t4_restart_en", 64'(layer_en), 64'(7'b0000001));
    check("t4_restart_graph", 64'(graph), 64'(0));
    wait_end(200, "t4r");
    check("t4r_pulses", 64'(pulses), 64'(7));
    @(negedge clk);

    // Zero-size batch
    start_batch(0);
    check("t5_done", 64'(done), 64'(1));
    check("t5_busy", 64'(busy), 64'(0));
    repeat (5) @(negedge clk);
    check("t5_pulses", 64'(pulses), 64'(0));
    check("t5_done_low", 64'(done), 64'(0));

    // Reset in the middle of layer 5
    start_batch(2);
    repeat (58) @(negedge clk);
    check("t6_pre_en", 64'(layer_en), 64'(7'b0100000));
    rst = 1'b0;
    @(negedge clk);
    check("t6_reset_outputs", 64'({layer_en, graph, layer_idx, busy, done, error}), 64'(0));
    check("t6_reset_cycles", 64'(cycle_count), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    start_batch(1);
    wait_end(200, "t6");
    check("t6_pulses", 64'(pulses), 64'(7));
    check("t6_cycles", 64'(cycle_count), 64'(77));
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
